sr_flag_arbiter: RTL and testbench



---
 rtl/sr_flag_arbiter.sv | 113 +++++++++++
 tb/tb_sr_flag_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter granting one set/clear/toggle command per clock
// into a shared bank of SR-style flag flip-flops.
module sr_flag_arbiter #(
    parameter int N_REQ   = 4,
    parameter int N_FLAGS = 8,
    parameter int IDXW    = 3,
    parameter int CNTW    = 8,
    localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      cmd_s,
    input  logic [N_REQ-1:0]      cmd_r,
    input  logic [N_REQ*IDXW-1:0] idx,
    output logic [N_REQ-1:0]      gnt,
    output logic                  gnt_valid,
    output logic [IDW-1:0]        gnt_id,
    output logic [N_FLAGS-1:0]    q,
    output logic [CNTW-1:0]       op_cnt
);

    logic [N_REQ-1:0]   gnt_r;
    logic               gnt_valid_r;
    logic [IDW-1:0]     gnt_id_r;
    logic [N_FLAGS-1:0] q_r;
    logic [CNTW-1:0]    op_cnt_r;
    logic [IDW-1:0]     ptr_r;

    logic [N_REQ-1:0]   elig_s;
    logic               found_s;
    logic [IDW-1:0]     win_s;
    logic [IDW-1:0]     cand_s;
    int unsigned        cand_int_s;
    logic [IDXW-1:0]    f_s;
    logic               set_s;
    logic               clr_s;
    logic [N_FLAGS-1:0] q_nxt_s;
    logic [N_REQ-1:0]   gnt_nxt_s;
    logic [IDW-1:0]     ptr_nxt_s;

    // Circular first-set search over eligible requesters starting at ptr.
    always_comb begin
        elig_s     = req & ~gnt_r;
        found_s    = 1'b0;
        win_s      = '0;
        cand_s     = '0;
        cand_int_s = 32'd0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_int_s = (32'(ptr_r) + 32'(k)) % 32'(N_REQ);
            cand_s     = IDW'(cand_int_s);
            if (!found_s && elig_s[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Winner's command decode, flag-bank next state, grant and pointer update.
    always_comb begin
        f_s       = idx[int'(win_s)*IDXW +: IDXW];
        set_s     = cmd_s[win_s];
        clr_s     = cmd_r[win_s];
        q_nxt_s   = q_r;
        gnt_nxt_s = '0;
        ptr_nxt_s = ptr_r;
        if (found_s && (32'(f_s) < 32'(N_FLAGS))) begin
            // s=r=1 toggles rather than leaving the SR state undefined
            case ({set_s, clr_s})
                2'b10:   q_nxt_s[f_s] = 1'b1;
                2'b01:   q_nxt_s[f_s] = 1'b0;
                2'b11:   q_nxt_s[f_s] = ~q_r[f_s];
                default: q_nxt_s = q_r;
            endcase
        end else begin
            q_nxt_s = q_r;
        end
        if (found_s) begin
            gnt_nxt_s[win_s] = 1'b1;
            ptr_nxt_s = (win_s == IDW'(N_REQ - 1)) ? '0 : win_s + IDW'(1);
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // State registers; async reset drops any grant pending in that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_r       <= '0;
            gnt_valid_r <= 1'b0;
            gnt_id_r    <= '0;
            q_r         <= '0;
            op_cnt_r    <= '0;
            ptr_r       <= '0;
        end else begin
            gnt_r       <= gnt_nxt_s;
            gnt_valid_r <= found_s;
            gnt_id_r    <= found_s ? win_s : '0;
            q_r         <= q_nxt_s;
            op_cnt_r    <= found_s ? op_cnt_r + CNTW'(1) : op_cnt_r;
            ptr_r       <= ptr_nxt_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_valid = gnt_valid_r;
    assign gnt_id    = gnt_id_r;
    assign q         = q_r;
    assign op_cnt    = op_cnt_r;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed-vector bench for sr_flag_arbiter (N_REQ=4, N_FLAGS=8, CNTW=4).
module tb_sr_flag_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [3:0]  cmd_s = 4'b0000;
    logic [3:0]  cmd_r = 4'b0000;
    logic [11:0] idx = 12'd0;
    logic [3:0]  gnt;
    logic        gnt_valid;
    logic [1:0]  gnt_id;
    logic [7:0]  q;
    logic [3:0]  op_cnt;

    int n_vec = 0;
    int n_err = 0;

    sr_flag_arbiter #(.N_REQ(4), .N_FLAGS(8), .IDXW(3), .CNTW(4)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd_s(cmd_s), .cmd_r(cmd_r), .idx(idx),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .q(q), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                           input logic [7:0] eq, input logic [3:0] ecnt);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(eg != 4'b0000));
        chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
        chk({tag, ".q"}, 32'(q), 32'(eq));
        chk({tag, ".cnt"}, 32'(op_cnt), 32'(ecnt));
    endtask

    initial begin
        // Reset held with all requests high
        req = 4'b1111;
        cmd_s = 4'b1111;
        tick();
        tick();
        chk_gnt("rst_hold", 4'b0000, 2'd0, 8'h00, 4'd0);
        rst = 1'b0;
        req = 4'b0000;
        cmd_s = 4'b0000;

        // Single requester 0: set flag 3, held req is not granted back-to-back
        req = 4'b0001; cmd_s = 4'b0001; cmd_r = 4'b0000; idx[2:0] = 3'd3;
        tick(); chk_gnt("single1", 4'b0001, 2'd0, 8'h08, 4'd1);
        tick(); chk_gnt("single_mask", 4'b0000, 2'd0, 8'h08, 4'd1);
        tick(); chk_gnt("single2", 4'b0001, 2'd0, 8'h08, 4'd2);
        req = 4'b0000;
        tick(); chk_gnt("single_idle", 4'b0000, 2'd0, 8'h08, 4'd2);

        // Async reset between edges clears outputs before the next edge
        #3 rst = 1'b1;
        #1 chk_gnt("async_rst", 4'b0000, 2'd0, 8'h00, 4'd0);
        tick();
        rst = 1'b0;

        // Round robin with all requests held, no-op commands
        cmd_s = 4'b0000; cmd_r = 4'b0000; idx = 12'd0;
        req = 4'b1111;
        tick(); chk_gnt("rr0", 4'b0001, 2'd0, 8'h00, 4'd1);
        tick(); chk_gnt("rr1", 4'b0010, 2'd1, 8'h00, 4'd2);
        tick(); chk_gnt("rr2", 4'b0100, 2'd2, 8'h00, 4'd3);
        tick(); chk_gnt("rr3", 4'b1000, 2'd3, 8'h00, 4'd4);
        tick(); chk_gnt("rr_wrap", 4'b0001, 2'd0, 8'h00, 4'd5);
        req = 4'b0000;
        tick(); chk_gnt("rr_idle", 4'b0000, 2'd0, 8'h00, 4'd5);

        // Bring ptr back to 0 via one grant to requester 3
        req = 4'b1000;
        tick(); chk_gnt("ptr_fix", 4'b1000, 2'd3, 8'h00, 4'd6);
        req = 4'b0000;
        tick();

        // Same-flag conflict at idx 5: set from 0 then clear from 1
        req = 4'b0011; cmd_s = 4'b0001; cmd_r = 4'b0010;
        idx[2:0] = 3'd5; idx[5:3] = 3'd5;
        tick(); chk_gnt("conf_set", 4'b0001, 2'd0, 8'h20, 4'd7);
        req = 4'b0010;
        tick(); chk_gnt("conf_clr", 4'b0010, 2'd1, 8'h00, 4'd8);
        req = 4'b0000;
        tick();

        // Toggle flag 2 three times from requester 2, then a no-op
        req = 4'b0100; cmd_s = 4'b0100; cmd_r = 4'b0100; idx = 12'd0; idx[8:6] = 3'd2;
        tick(); chk_gnt("tog1", 4'b0100, 2'd2, 8'h04, 4'd9);
        tick(); chk_gnt("tog_mask", 4'b0000, 2'd0, 8'h04, 4'd9);
        tick(); chk_gnt("tog2", 4'b0100, 2'd2, 8'h00, 4'd10);
        tick();
        tick(); chk_gnt("tog3", 4'b0100, 2'd2, 8'h04, 4'd11);
        cmd_s = 4'b0000; cmd_r = 4'b0000;
        tick();
        tick(); chk_gnt("noop", 4'b0100, 2'd2, 8'h04, 4'd12);
        req = 4'b0000;
        tick();

        // Counter wrap: ptr=3, four grants take op_cnt 12 -> 0
        req = 4'b1111;
        tick(); chk_gnt("cw3", 4'b1000, 2'd3, 8'h04, 4'd13);
        tick(); chk_gnt("cw0", 4'b0001, 2'd0, 8'h04, 4'd14);
        tick(); chk_gnt("cw1", 4'b0010, 2'd1, 8'h04, 4'd15);
        tick(); chk_gnt("cw_wrap", 4'b0100, 2'd2, 8'h04, 4'd0);
        req = 4'b0000;
        tick();

        // Reset mid-grant: pending set of flag 7 is lost, ptr returns to 0
        req = 4'b1001; cmd_s = 4'b0001; cmd_r = 4'b0000; idx = 12'd0; idx[2:0] = 3'd7;
        #2 rst = 1'b1;
        #1 chk_gnt("midrst", 4'b0000, 2'd0, 8'h00, 4'd0);
        tick(); chk_gnt("midrst_edge", 4'b0000, 2'd0, 8'h00, 4'd0);
        rst = 1'b0;
        tick(); chk_gnt("post_rst", 4'b0001, 2'd0, 8'h80, 4'd1);
        req = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
